// File: rtl/lock_pkg.sv
// Shared constants and state encoding for the lock supervisor and password checker.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKOUT = 2'd1,
        RELEASE = 2'd2,
        PERMA   = 2'd3
    } state_t;

    localparam int MAX_FAIL_DEF       = 3;
    localparam int MAX_LOCKOUTS_DEF   = 2;
    localparam int RELEASE_CYCLES_DEF = 3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic s_p0;
    logic s_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_p0 <= 1'b0;
            s_p1 <= 1'b0;
        end else begin
            s_p0 <= din;
            s_p1 <= s_p0;
        end
    end

    assign dout = s_p1;

endmodule

// File: rtl/lockout_ctrl.sv
// Failed-attempt supervisor driving stop_timer EN; LOCKOUT_ESCALATE_EN adds
// a permanent-lock state that only admin_clr can leave.
module lockout_ctrl
    import lock_pkg::*;
#(
    parameter int MAX_FAIL       = MAX_FAIL_DEF,
    parameter int MAX_LOCKOUTS   = MAX_LOCKOUTS_DEF,
    parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    input  logic                          check_valid,
    input  logic                          check_pass,
    input  logic                          timer_done,
    input  logic                          admin_clr,
    output logic                          timer_en,
    output logic                          locked,
    output logic                          grant,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          alarm
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int RW = $clog2(RELEASE_CYCLES);

    state_t          state, state_nx;
    logic [FW-1:0]   fail_nx;
    logic [RW-1:0]   rel_cnt, rel_nx;
    logic            grant_nx;
    logic            done_s;

    sync_2ff u_done_sync (
        .clk  (clk_50m),
        .rst  (rst),
        .din  (timer_done),
        .dout (done_s)
    );

`ifdef LOCKOUT_ESCALATE_EN
    localparam int LW = $clog2(MAX_LOCKOUTS + 1);
    logic [LW-1:0] lock_cnt, lock_nx;
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {admin_clr, MAX_LOCKOUTS[0]};
`endif

    always_comb begin
        state_nx = state;
        fail_nx  = fail_cnt;
        rel_nx   = rel_cnt;
        grant_nx = 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
        lock_nx  = lock_cnt;
`endif
        case (state)
            IDLE: begin
                if (check_valid && check_pass) begin
                    grant_nx = 1'b1;
                    fail_nx  = '0;
`ifdef LOCKOUT_ESCALATE_EN
                    lock_nx  = '0;
`endif
                end else if (check_valid) begin
                    if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                        state_nx = LOCKOUT;
                        fail_nx  = '0;
`ifdef LOCKOUT_ESCALATE_EN
                        if (lock_cnt != LW'(MAX_LOCKOUTS))
                            lock_nx = lock_cnt + 1'b1;
`endif
                    end else begin
                        fail_nx = fail_cnt + 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                rel_nx = '0;
                if (done_s)
                    state_nx = RELEASE;
            end
            RELEASE: begin
                // Hold EN low long enough for the timer's done to flush through the synchronizer.
                if (rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
                    rel_nx   = '0;
                    state_nx = IDLE;
`ifdef LOCKOUT_ESCALATE_EN
                    if (lock_cnt == LW'(MAX_LOCKOUTS))
                        state_nx = PERMA;
`endif
                end else begin
                    rel_nx = rel_cnt + 1'b1;
                end
            end
            default: begin
`ifdef LOCKOUT_ESCALATE_EN
                if (admin_clr) begin
                    state_nx = IDLE;
                    fail_nx  = '0;
                end
`else
                state_nx = IDLE;
`endif
            end
        endcase
`ifdef LOCKOUT_ESCALATE_EN
        if (admin_clr)
            lock_nx = '0;
`endif
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fail_cnt <= '0;
            rel_cnt  <= '0;
            grant    <= 1'b0;
            timer_en <= 1'b0;
            locked   <= 1'b0;
            alarm    <= 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
            lock_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            fail_cnt <= fail_nx;
            rel_cnt  <= rel_nx;
            grant    <= grant_nx;
            timer_en <= (state_nx == LOCKOUT);
            locked   <= (state_nx != IDLE);
`ifdef LOCKOUT_ESCALATE_EN
            alarm    <= (state_nx == PERMA);
            lock_cnt <= lock_nx;
`else
            alarm    <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed bench for lockout_ctrl; escalation scenario runs when LOCKOUT_ESCALATE_EN is defined.
module tb_lockout_ctrl;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic       check_valid = 1'b0;
    logic       check_pass = 1'b0;
    logic       timer_done = 1'b0;
    logic       admin_clr = 1'b0;
    logic       timer_en;
    logic       locked;
    logic       grant;
    logic [1:0] fail_cnt;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    lockout_ctrl #(.MAX_FAIL(3), .MAX_LOCKOUTS(2), .RELEASE_CYCLES(3)) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .check_valid (check_valid),
        .check_pass  (check_pass),
        .timer_done  (timer_done),
        .admin_clr   (admin_clr),
        .timer_en    (timer_en),
        .locked      (locked),
        .grant       (grant),
        .fail_cnt    (fail_cnt),
        .alarm       (alarm)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic submit(input logic pass);
        check_valid = 1'b1;
        check_pass  = pass;
        tick();
        check_valid = 1'b0;
        check_pass  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_timer_en"}, timer_en, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
        check({tag, "_alarm"}, alarm, 0);
    endtask

    task automatic full_lockout();
        submit(1'b0);
        submit(1'b0);
        submit(1'b0);
        repeat (5) tick();
        timer_done = 1'b1;
        repeat (3) tick();
        timer_done = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset");

        // 1: single pass
        submit(1'b1);
        check("t1_grant_hi", grant, 1);
        check("t1_fail_cnt", fail_cnt, 0);
        check("t1_timer_en", timer_en, 0);
        tick();
        check("t1_grant_lo", grant, 0);

        // 2: fail, fail, pass
        submit(1'b0);
        check("t2_fail1", fail_cnt, 1);
        check("t2_grant_after_fail", grant, 0);
        submit(1'b0);
        check("t2_fail2", fail_cnt, 2);
        submit(1'b1);
        check("t2_fail_clr", fail_cnt, 0);
        check("t2_grant", grant, 1);
        check("t2_timer_en", timer_en, 0);
        tick();

        // 3/4: lockout entry, ignored checks, done handshake, release
        submit(1'b0);
        submit(1'b0);
        check("t3_timer_en_pre", timer_en, 0);
        submit(1'b0);
        check("t3_timer_en", timer_en, 1);
        check("t3_locked", locked, 1);
        check("t3_fail_cnt", fail_cnt, 0);
        submit(1'b1);
        check("t4_lock_pass_grant", grant, 0);
        submit(1'b0);
        check("t4_lock_fail_cnt", fail_cnt, 0);
        repeat (96) tick();
        check("t3_timer_en_wait", timer_en, 1);
        timer_done = 1'b1;
        tick();
        tick();
        check("t3_timer_en_2cyc", timer_en, 1);
        tick();
        check("t3_timer_en_drop", timer_en, 0);
        check("t3_locked_rel", locked, 1);
        timer_done = 1'b0;
        submit(1'b1);
        check("t4_rel_pass_grant", grant, 0);
        check("t4_rel_locked", locked, 1);
        submit(1'b0);
        check("t4_rel_fail_cnt", fail_cnt, 0);
        check("t4_rel_locked2", locked, 1);
        tick();
        check("t3_unlocked", locked, 0);
        check("t3_fail_idle", fail_cnt, 0);
        check("t3_alarm", alarm, 0);
        submit(1'b1);
        check("t3_grant_after", grant, 1);
        tick();

        // 5: async reset mid-lockout
        submit(1'b0);
        submit(1'b0);
        submit(1'b0);
        check("t5_timer_en_on", timer_en, 1);
        repeat (50) tick();
        #3 rst = 1'b1;
        #1;
        check_idle_outputs("t5_async");
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("t5_after");
        submit(1'b0);
        check("t5_fail_restart", fail_cnt, 1);
        check("t5_timer_en_idle", timer_en, 0);
        submit(1'b1);
        check("t5_grant", grant, 1);
        tick();

`ifdef LOCKOUT_ESCALATE_EN
        // 6: two lockouts escalate to permanent lock
        full_lockout();
        check("t6_first_unlocked", locked, 0);
        check("t6_first_alarm", alarm, 0);
        full_lockout();
        check("t6_perma_locked", locked, 1);
        check("t6_perma_alarm", alarm, 1);
        check("t6_perma_timer_en", timer_en, 0);
        submit(1'b1);
        check("t6_perma_grant", grant, 0);
        submit(1'b0);
        check("t6_perma_fail", fail_cnt, 0);
        check("t6_perma_hold", alarm, 1);
        admin_clr = 1'b1;
        tick();
        admin_clr = 1'b0;
        check("t6_clr_alarm", alarm, 0);
        check("t6_clr_locked", locked, 0);
        submit(1'b1);
        check("t6_clr_grant", grant, 1);
        tick();
`else
        full_lockout();
        check("t6_noesc_locked", locked, 0);
        full_lockout();
        check("t6_noesc_locked2", locked, 0);
        check("t6_noesc_alarm", alarm, 0);
        admin_clr = 1'b1;
        tick();
        admin_clr = 1'b0;
        check("t6_noesc_admin", locked, 0);
        submit(1'b1);
        check("t6_noesc_grant", grant, 1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
